// File: rtl/pkg_sprites.sv
// Shared sprite definitions: index constants, reset position table and the
// pack order used on the ColunasSprites / LinhasSprites buses.
package pkg_sprites;

    localparam int unsigned NUM_SPRITES = 6;
    localparam int unsigned POS_W       = 4;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned BUS_W       = NUM_SPRITES * POS_W;

    localparam logic [SEL_W-1:0] SPR_CELULA_PRETA = 3'd0;
    localparam logic [SEL_W-1:0] SPR_LIXO1        = 3'd1;
    localparam logic [SEL_W-1:0] SPR_LIXO2        = 3'd2;
    localparam logic [SEL_W-1:0] SPR_LIXO3        = 3'd3;
    localparam logic [SEL_W-1:0] SPR_ROBO         = 3'd4;
    localparam logic [SEL_W-1:0] SPR_CURSOR       = 3'd5;

    // Element [i] holds sprite index i.
    typedef logic [NUM_SPRITES-1:0][POS_W-1:0] pos_vec_t;

    localparam pos_vec_t COL_RESET = {4'd6, 4'd1, 4'd1, 4'd10, 4'd6, 4'd1};
    localparam pos_vec_t LIN_RESET = {4'd3, 4'd6, 4'd2, 4'd5, 4'd3, 4'd5};

    // Sprite 0 (CelulaPreta) lands in the most significant nibble.
    function automatic logic [BUS_W-1:0] pack_sprites(input pos_vec_t v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

endpackage

// File: rtl/filtro_botao.sv
// Button conditioner: 2-flop synchronizer, debounce counter and a single
// accept pulse per debounced press, re-armed only by a debounced release.
module filtro_botao #(
    parameter int unsigned DebounceCiclos = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    output logic aceite
);

    localparam int unsigned CW = $clog2(DebounceCiclos + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DebounceCiclos);
    localparam logic [CW-1:0] CNT_LAST = CW'(DebounceCiclos - 1);

    logic [1:0]    sinc;
    logic          nivel;
    logic          armado;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive cycles sinc[1] has equalled nivel, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            sinc   <= 2'b00;
            nivel  <= 1'b0;
            armado <= 1'b0;
            cnt    <= '0;
            aceite <= 1'b0;
        end else begin
            sinc   <= {sinc[0], botao};
            aceite <= 1'b0;
            if (sinc[1] != nivel) begin
                nivel <= sinc[1];
                cnt   <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    if (nivel && armado) begin
                        aceite <= 1'b1;
                        armado <= 1'b0;
                    end else if (!nivel) begin
                        armado <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/controle_sprites.sv
// Sprite-position controller: shadow positions updated by buttons and game
// writes, copied to the Grafico buses only on a v_sync falling edge.
module controle_sprites
    import pkg_sprites::*;
#(
    parameter int unsigned MaxColuna      = 11,
    parameter int unsigned MaxLinha       = 7,
    parameter int unsigned DebounceCiclos = 250000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             v_sync,
    input  logic             Cima,
    input  logic             Baixo,
    input  logic             Esquerda,
    input  logic             Direita,
    input  logic             SpriteWrite,
    input  logic [SEL_W-1:0] SpriteSel,
    input  logic [POS_W-1:0] SpriteColuna,
    input  logic [POS_W-1:0] SpriteLinha,
    output logic [BUS_W-1:0] ColunasSprites,
    output logic [BUS_W-1:0] LinhasSprites,
    output logic             FrameAtualizado
);

    localparam logic [POS_W-1:0] COL_MAX = POS_W'(MaxColuna);
    localparam logic [POS_W-1:0] LIN_MAX = POS_W'(MaxLinha);

    logic     ac_cima, ac_baixo, ac_esq, ac_dir;
    logic     vs_q;
    logic     borda_c;
    logic     escrita_ok_c;
    pos_vec_t col_sh, lin_sh;
    pos_vec_t col_nxt, lin_nxt;

    filtro_botao #(.DebounceCiclos(DebounceCiclos)) u_cima (
        .clk(Clock), .reset(Reset), .botao(Cima), .aceite(ac_cima)
    );
    filtro_botao #(.DebounceCiclos(DebounceCiclos)) u_baixo (
        .clk(Clock), .reset(Reset), .botao(Baixo), .aceite(ac_baixo)
    );
    filtro_botao #(.DebounceCiclos(DebounceCiclos)) u_esq (
        .clk(Clock), .reset(Reset), .botao(Esquerda), .aceite(ac_esq)
    );
    filtro_botao #(.DebounceCiclos(DebounceCiclos)) u_dir (
        .clk(Clock), .reset(Reset), .botao(Direita), .aceite(ac_dir)
    );

    assign borda_c      = vs_q && !v_sync;
    assign escrita_ok_c = SpriteWrite
                        && (SpriteSel <= SPR_CURSOR)
                        && (SpriteColuna <= COL_MAX)
                        && (SpriteLinha <= LIN_MAX);

    // Cursor move (one direction by priority), then game write, which overrides it.
    always_comb begin
        col_nxt = col_sh;
        lin_nxt = lin_sh;
        if (ac_cima) begin
            lin_nxt[SPR_CURSOR] = (lin_sh[SPR_CURSOR] == '0) ? LIN_MAX
                                : lin_sh[SPR_CURSOR] - POS_W'(1);
        end else if (ac_baixo) begin
            lin_nxt[SPR_CURSOR] = (lin_sh[SPR_CURSOR] >= LIN_MAX) ? '0
                                : lin_sh[SPR_CURSOR] + POS_W'(1);
        end else if (ac_esq) begin
            col_nxt[SPR_CURSOR] = (col_sh[SPR_CURSOR] == '0) ? COL_MAX
                                : col_sh[SPR_CURSOR] - POS_W'(1);
        end else if (ac_dir) begin
            col_nxt[SPR_CURSOR] = (col_sh[SPR_CURSOR] >= COL_MAX) ? '0
                                : col_sh[SPR_CURSOR] + POS_W'(1);
        end
        if (escrita_ok_c) begin
            col_nxt[SpriteSel] = SpriteColuna;
            lin_nxt[SpriteSel] = SpriteLinha;
        end
    end

    // Edge register starts low so leaving reset never fakes a frame boundary.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vs_q            <= 1'b0;
            col_sh          <= COL_RESET;
            lin_sh          <= LIN_RESET;
            ColunasSprites  <= pack_sprites(COL_RESET);
            LinhasSprites   <= pack_sprites(LIN_RESET);
            FrameAtualizado <= 1'b0;
        end else begin
            vs_q            <= v_sync;
            col_sh          <= col_nxt;
            lin_sh          <= lin_nxt;
            FrameAtualizado <= borda_c;
            if (borda_c) begin
                ColunasSprites <= pack_sprites(col_sh);
                LinhasSprites  <= pack_sprites(lin_sh);
            end
        end
    end

endmodule
